// File: rtl/reaction_pkg.sv
// Shared definitions for the multi-player reaction timer: FSM states,
// LFSR constants, seven-segment glyph codes/patterns and small helpers.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GO,
        S_DONE,
        S_FOUL
    } state_t;

    // Right-shifting Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1.
    // Taps 16,14,13,11 appear as bits 0,2,3,5 of the shifting register.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'b0000_0000_0010_1101;

    // Glyph codes handed to the display scanner: 0-9 are decimal digits.
    typedef logic [3:0] glyph_t;
    localparam glyph_t GLYPH_DASH  = 4'hA;
    localparam glyph_t GLYPH_BLANK = 4'hF;

    // Segment patterns {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

    function automatic logic [6:0] glyph_to_seg(input glyph_t g);
        case (g)
            4'd0:       return SEG_0;
            4'd1:       return SEG_1;
            4'd2:       return SEG_2;
            4'd3:       return SEG_3;
            4'd4:       return SEG_4;
            4'd5:       return SEG_5;
            4'd6:       return SEG_6;
            4'd7:       return SEG_7;
            4'd8:       return SEG_8;
            4'd9:       return SEG_9;
            GLYPH_DASH: return SEG_DASH;
            default:    return SEG_BLANK;
        endcase
    endfunction

    // Four-digit BCD increment with ripple carry; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] cur);
        logic [15:0] res;
        logic        carry;
        res   = cur;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (res[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Binary to four BCD digits, used for elaboration-time constants.
    function automatic logic [15:0] to_bcd4(input int unsigned value);
        return {4'(value / 1000 % 10), 4'(value / 100 % 10),
                4'(value / 10 % 10),   4'(value % 10)};
    endfunction

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment driver. Steps through digits 0..7,
// one digit per SCAN_HZ tick, with active-low one-hot digit select and
// registered segment outputs that always match the selected digit.
module seg_scan
    import reaction_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0][3:0] glyphs,
    output logic [7:0]      dig,
    output logic [6:0]      codeout
);

    localparam int DIV = (CLK_HZ / SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic          scan_tick;
    logic [2:0]    idx;
    logic [2:0]    idx_next;

    assign scan_tick = (pre_cnt == PW'(DIV - 1));
    assign idx_next  = scan_tick ? idx + 3'd1 : idx;

    // Scan prescaler: free-running divide by CLK_HZ/SCAN_HZ.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from the values sampled at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (scan_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Digit pointer and registered select/segment outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 3'd0;
            dig     <= 8'hFE;
            codeout <= SEG_BLANK;
        end else begin
            idx     <= idx_next;
            dig     <= ~(8'h01 << idx_next);
            codeout <= glyph_to_seg(glyphs[idx_next]);
        end
    end

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction-time tester. After a start edge it waits a
// pseudo-random delay, lights LED and times the first stop press in ms,
// flagging false starts and ending the round at TIMEOUT_MS.
// Optional feature macro: BEST_TIME_EN adds best_bcd/best_player, a
// best-time record that persists across rounds until clear.
module reaction_timer_mp
    import reaction_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int N_PLAYERS    = 4,
    parameter int MIN_DELAY_MS = 2000,
    parameter int MAX_DELAY_MS = 6000,
    parameter int TIMEOUT_MS   = 9999,
    parameter int SCAN_HZ      = 1000
) (
    input  logic                 clk_50M,
    input  logic                 clear,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] stop,
    output logic                 LED,
    output logic [2:0]           winner,
    output logic                 winner_valid,
    output logic [N_PLAYERS-1:0] false_start,
    output logic [15:0]          react_bcd,
`ifdef BEST_TIME_EN
    output logic [15:0]          best_bcd,
    output logic [2:0]           best_player,
`endif
    output logic [7:0]           DIG,
    output logic [6:0]           codeout
);

    localparam int          MS_DIV      = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int          MS_W        = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int          RANGE_MS    = MAX_DELAY_MS - MIN_DELAY_MS;
    localparam logic [15:0] TIMEOUT_BCD = to_bcd4(TIMEOUT_MS);

    state_t                 state;
    logic [N_PLAYERS-1:0]   stop_meta;
    logic [N_PLAYERS-1:0]   stop_sync;
    logic                   start_meta;
    logic                   start_sync;
    logic                   start_prev;
    logic                   start_edge;
    logic [MS_W-1:0]        ms_cnt;
    logic                   ms_tick;
    logic [15:0]            lfsr;
    logic [15:0]            delay_next;
    logic [15:0]            delay_ms;
    logic [15:0]            wait_cnt;
    logic [2:0]             stop_first;
    logic [2:0]             foul_first;
    logic [7:0][3:0]        glyphs;

    assign start_edge = start_sync & ~start_prev;
    assign ms_tick    = (ms_cnt == MS_W'(MS_DIV - 1));
    assign delay_next = 16'(MIN_DELAY_MS) + 16'((32'(lfsr) * 32'(RANGE_MS)) >> 16);
    assign stop_first = lowest_set(8'(stop_sync));
    assign foul_first = lowest_set(8'(false_start));

    // Two-flop synchronisers for stop and start, plus start edge history.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            stop_meta  <= '0;
            stop_sync  <= '0;
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            stop_meta  <= stop;
            stop_sync  <= stop_meta;
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    // Free-running millisecond prescaler; never cleared by the FSM.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            ms_cnt <= '0;
        end else if (ms_tick) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    // Random source: LFSR advances every clock.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Round FSM with registered results and LED.
    always_ff @(posedge clk_50M or posedge clear) begin
        if (clear) begin
            state        <= S_IDLE;
            LED          <= 1'b0;
            winner       <= 3'd0;
            winner_valid <= 1'b0;
            false_start  <= '0;
            react_bcd    <= 16'h0000;
            delay_ms     <= 16'd0;
            wait_cnt     <= 16'd0;
`ifdef BEST_TIME_EN
            best_bcd     <= 16'h9999;
            best_player  <= 3'd0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FOUL: begin
                    if (start_edge) begin
                        state        <= S_ARM;
                        delay_ms     <= delay_next;
                        wait_cnt     <= 16'd0;
                        false_start  <= '0;
                        winner_valid <= 1'b0;
                        react_bcd    <= 16'h0000;
                    end
                end
                S_ARM: begin
                    if (|stop_sync) begin
                        false_start <= stop_sync;
                        state       <= S_FOUL;
                    end else if (wait_cnt == delay_ms) begin
                        LED   <= 1'b1;
                        state <= S_GO;
                    end else if (ms_tick) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_GO: begin
                    // A press beats a timeout landing in the same cycle.
                    if (|stop_sync) begin
                        winner       <= stop_first;
                        winner_valid <= 1'b1;
                        LED          <= 1'b0;
                        state        <= S_DONE;
`ifdef BEST_TIME_EN
                        if (react_bcd < best_bcd) begin
                            best_bcd    <= react_bcd;
                            best_player <= stop_first;
                        end
`endif
                    end else if (react_bcd == TIMEOUT_BCD) begin
                        LED   <= 1'b0;
                        state <= S_DONE;
                    end else if (ms_tick) begin
                        react_bcd <= bcd_inc(react_bcd);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display content: reaction digits (or dashes on a foul) and player number.
    // NOTE: combinational blocks assign a full default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        glyphs = {8{GLYPH_BLANK}};
        if (state == S_FOUL) begin
            glyphs[0] = GLYPH_DASH;
            glyphs[1] = GLYPH_DASH;
            glyphs[2] = GLYPH_DASH;
            glyphs[3] = GLYPH_DASH;
            glyphs[7] = {1'b0, foul_first} + 4'd1;
        end else begin
            glyphs[0] = react_bcd[3:0];
            glyphs[1] = react_bcd[7:4];
            glyphs[2] = react_bcd[11:8];
            glyphs[3] = react_bcd[15:12];
            if (state == S_DONE && winner_valid) begin
                glyphs[7] = {1'b0, winner} + 4'd1;
            end
        end
    end

    seg_scan #(
        .CLK_HZ (CLK_HZ),
        .SCAN_HZ(SCAN_HZ)
    ) u_seg_scan (
        .clk    (clk_50M),
        .rst    (clear),
        .glyphs (glyphs),
        .dig    (DIG),
        .codeout(codeout)
    );

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Self-checking bench for reaction_timer_mp with CLK_HZ=1000 (one cycle per
// ms). Randomised rounds are compared against a round-level model built from
// the timing rules: 2-stage input sync, delay formula from the LFSR value, and
// the BCD millisecond count. Define BEST_TIME_EN to cover the best-time record.
module tb_reaction_timer_mp;

    localparam int N       = 4;
    localparam int MIN_D   = 2000;
    localparam int MAX_D   = 6000;
    localparam int TIMEOUT = 9999;
    localparam int K_OTHER = 0;
    localparam int K_DONE  = 1;
    localparam int K_FOUL  = 2;

    logic         clk = 1'b0;
    logic         clear;
    logic         start;
    logic [N-1:0] stop;
    logic         LED;
    logic [2:0]   winner;
    logic         winner_valid;
    logic [N-1:0] false_start;
    logic [15:0]  react_bcd;
    logic [7:0]   DIG;
    logic [6:0]   codeout;
`ifdef BEST_TIME_EN
    logic [15:0]  best_bcd;
    logic [2:0]   best_player;
`endif

    reaction_timer_mp #(
        .CLK_HZ      (1000),
        .N_PLAYERS   (N),
        .MIN_DELAY_MS(MIN_D),
        .MAX_DELAY_MS(MAX_D),
        .TIMEOUT_MS  (TIMEOUT),
        .SCAN_HZ     (1000)
    ) dut (
        .clk_50M     (clk),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .LED         (LED),
        .winner      (winner),
        .winner_valid(winner_valid),
        .false_start (false_start),
        .react_bcd   (react_bcd),
`ifdef BEST_TIME_EN
        .best_bcd    (best_bcd),
        .best_player (best_player),
`endif
        .DIG         (DIG),
        .codeout     (codeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference random source: seed on clear, one right-shift step per clock
    // with taps 16,14,13,11 (bits 0,2,3,5).
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge clear) begin
        if (clear) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // Round-level model of what the display and result outputs should hold.
    int         m_kind;
    int         m_react;
    int         m_winner;
    bit         m_valid;
    logic [3:0] m_fs;
`ifdef BEST_TIME_EN
    int         m_best;
    int         m_best_player;
`endif

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int delay_of(input logic [15:0] l);
        return MIN_D + int'((longint'(l) * longint'(MAX_D - MIN_D)) >>> 16);
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        int p;
        if (idx >= 4) begin
            if (idx == 7 && m_kind == K_FOUL) return seg_of(lowest(m_fs) + 1);
            if (idx == 7 && m_kind == K_DONE && m_valid) return seg_of(m_winner + 1);
            return 7'h00;
        end
        if (m_kind == K_FOUL) return 7'h40;
        p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        return seg_of((m_react / p) % 10);
    endfunction

    // Watch one full scan and compare each selected digit's segments.
    task automatic check_display();
        int idx;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idx = 0;
            for (int b = 0; b < 8; b++) if (!DIG[b]) idx = b;
            check("dig_onehot", 32'($onehot(~DIG)), 1);
            check($sformatf("seg_digit%0d", idx), codeout, exp_seg(idx));
        end
    endtask

    task automatic do_reset();
        logic [7:0] exp_dig;
        @(negedge clk);
        clear = 1'b1;
        start = 1'b0;
        stop  = '0;
        repeat (2) @(negedge clk);
        check("rst_led", LED, 0);
        check("rst_winner", winner, 0);
        check("rst_valid", winner_valid, 0);
        check("rst_false_start", false_start, 0);
        check("rst_react", react_bcd, 0);
        check("rst_dig", DIG, 8'hFE);
        check("rst_codeout", codeout, 0);
        m_kind  = K_OTHER;
        m_react = 0;
        m_valid = 1'b0;
        m_fs    = '0;
`ifdef BEST_TIME_EN
        check("rst_best_bcd", best_bcd, 16'h9999);
        check("rst_best_player", best_player, 0);
        m_best        = 9999;
        m_best_player = 0;
`endif
        clear = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_dig = ~(8'h01 << (i % 8));
            check("dig_scan", DIG, exp_dig);
        end
    endtask

    // Start a round (caller sits at a negedge) and measure cycles until LED.
    // The FSM sees the start edge on the 3rd clock, using the LFSR value held
    // after the 2nd; LED follows delay+1 clocks after ARM is entered.
    task automatic run_to_led(input bit poke_arm);
        int n;
        int exp_wait;
        start    = 1'b1;
        n        = 0;
        exp_wait = -1;
        while (LED !== 1'b1 && n < 7000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 2) exp_wait = delay_of(m_lfsr) + 4;
            if (poke_arm && n == 50) start = 1'b1;
            if (poke_arm && n == 51) start = 1'b0;
        end
        check("led_rise_cycle", n, exp_wait);
        check("go_react_zero", react_bcd, 0);
        check("go_valid_clear", winner_valid, 0);
        check("go_false_start_clear", false_start, 0);
        m_kind  = K_OTHER;
        m_react = 0;
        m_valid = 1'b0;
        m_fs    = '0;
    endtask

    // Press `mask` gap cycles after LED was seen; the count keeps running
    // through the two sync stages, so the result is gap+2 ms.
    task automatic finish_with_stop(input int gap, input logic [3:0] mask);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        stop = mask;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("go_until_sync", LED, 1);
        @(posedge clk);
        @(negedge clk);
        m_kind   = K_DONE;
        m_react  = gap + 2;
        m_valid  = 1'b1;
        m_winner = lowest(mask);
        check("done_led", LED, 0);
        check("done_valid", winner_valid, 1);
        check("done_winner", winner, m_winner);
        check("done_react", react_bcd, bcd(m_react));
`ifdef BEST_TIME_EN
        if (m_react < m_best) begin
            m_best        = m_react;
            m_best_player = m_winner;
        end
        check("best_bcd", best_bcd, bcd(m_best));
        check("best_player", best_player, m_best_player);
`endif
        check_display();
        stop = '0;
        repeat (4) @(negedge clk);
        check("done_holds", react_bcd, bcd(m_react));
    endtask

    // Press `mask` t cycles after start; expect FOUL 3 clocks later.
    task automatic foul_round(input int t, input logic [3:0] mask);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (t - 1) @(posedge clk);
        @(negedge clk);
        stop = mask;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("foul_pending", false_start, 0);
        @(posedge clk);
        @(negedge clk);
        check("foul_flags", false_start, mask);
        check("foul_led", LED, 0);
        check("foul_valid", winner_valid, 0);
        m_kind  = K_FOUL;
        m_fs    = mask;
        m_react = 0;
        m_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("foul_holds", false_start, mask);
        check("foul_led_stays", LED, 0);
        check_display();
    endtask

    initial begin
        logic [3:0] mask;
        int         n;
        clear = 1'b0;
        start = 1'b0;
        stop  = '0;
        do_reset();
        check_display();

        // Normal round: player 2 presses 500 ms into GO.
        run_to_led(1'b0);
        finish_with_stop(498, 4'b0100);

        // False start by player 1, then the same button held into a new round.
        foul_round(100, 4'b0010);
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("held_flags_cleared", false_start, 0);
        @(posedge clk);
        @(negedge clk);
        check("held_stop_fouls", false_start, 4'b0010);
        stop = '0;
        repeat (4) @(negedge clk);

        // Tie: players 3 and 0 in the same cycle; lowest index wins.
        run_to_led(1'b0);
        finish_with_stop($urandom_range(50, 600), 4'b1001);

        // Timeout round with start pulses during ARM and GO that must be ignored.
        run_to_led(1'b1);
        n = 0;
        while (LED === 1'b1 && n < 10100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 100) start = 1'b1;
            if (n == 101) start = 1'b0;
            if (n == 200) check("go_react_200", react_bcd, bcd(200));
        end
        check("timeout_cycles", n, TIMEOUT + 1);
        check("timeout_react", react_bcd, 16'h9999);
        check("timeout_valid", winner_valid, 0);
        m_kind  = K_DONE;
        m_react = TIMEOUT;
        m_valid = 1'b0;
        check_display();

        // Randomised rounds.
        for (int r = 0; r < 3; r++) begin
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                run_to_led(1'b0);
                finish_with_stop($urandom_range(50, 900), mask);
            end else begin
                foul_round($urandom_range(10, 1500), mask);
                stop = '0;
                repeat (4) @(negedge clk);
            end
        end

`ifdef BEST_TIME_EN
        // Best time over rounds of 700, 400 and 900 ms, then clear mid-GO.
        do_reset();
        run_to_led(1'b0);
        finish_with_stop(698, 4'($urandom_range(1, 15)));
        run_to_led(1'b0);
        finish_with_stop(398, 4'($urandom_range(1, 15)));
        run_to_led(1'b0);
        finish_with_stop(898, 4'($urandom_range(1, 15)));
        check("best_after_three", best_bcd, 16'h0400);
        run_to_led(1'b0);
        repeat (100) @(negedge clk);
        #2 clear = 1'b1;
        #1;
        check("clear_led", LED, 0);
        check("clear_best_bcd", best_bcd, 16'h9999);
        check("clear_best_player", best_player, 0);
        check("clear_react", react_bcd, 0);
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
